// File: rtl/lsb_multi_cdb_pkg.sv
//------------------------------------------------------------------------------
// lsb_multi_cdb_pkg : shared constants for the multi-CDB load/store buffer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lsb_multi_cdb_pkg;

  localparam int         LSB_ROB_W = 4;
  localparam logic [LSB_ROB_W:0] DEP_READY = '1;
  localparam logic [31:0] IO_ADDR   = 32'h0003_0000;

  localparam logic [5:0] OP_LB = 6'h01;
  localparam logic [5:0] OP_LH = 6'h02;
  localparam logic [5:0] OP_LW = 6'h03;
  localparam logic [5:0] OP_SB = 6'h08;
  localparam logic [5:0] OP_SH = 6'h09;
  localparam logic [5:0] OP_SW = 6'h0A;

endpackage

`default_nettype wire

// File: rtl/lsb_cdb_match.sv
//------------------------------------------------------------------------------
// lsb_cdb_match : resolves one DEP/value pair against the CDB bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsb_cdb_match
  import lsb_multi_cdb_pkg::*;
#(
  parameter int N_CDB  = 2,
  parameter int XLEN   = 32,
  parameter int ROB_W  = 4,
  parameter bit ADD_EN = 1'b1
) (
  input  logic [ROB_W:0]       q_i,
  input  logic [XLEN-1:0]      v_i,
  input  logic [N_CDB-1:0]     cdb_valid_i,
  input  logic [N_CDB*ROB_W-1:0] cdb_id_i,
  input  logic [N_CDB*XLEN-1:0]  cdb_val_i,
  output logic [ROB_W:0]       q_o,
  output logic [XLEN-1:0]      v_o
);

  // Scan high to low so the lowest matching channel is the one that sticks.
  always_comb begin
    q_o = q_i;
    v_o = v_i;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (cdb_valid_i[k] && (q_i == {1'b0, cdb_id_i[k*ROB_W +: ROB_W]})) begin
        q_o = '1;
        v_o = ADD_EN ? (cdb_val_i[k*XLEN +: XLEN] + v_i) : cdb_val_i[k*XLEN +: XLEN];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsb_multi_cdb.sv
//------------------------------------------------------------------------------
// lsb_multi_cdb : in-order load/store buffer snooping N_CDB writeback channels
// Optional IO guard on head loads: LSB_IO_GUARD_EN
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsb_multi_cdb
  import lsb_multi_cdb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int N_CDB = 2,
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    stall,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic                    enq_is_store,
  input  logic [OP_W-1:0]         enq_op,
  input  logic [ROB_W-1:0]        enq_rob_id,
  input  logic [ROB_W:0]          enq_q1,
  input  logic [XLEN-1:0]         enq_v1,
  input  logic [XLEN-1:0]         enq_imm,
  input  logic [ROB_W:0]          enq_q2,
  input  logic [XLEN-1:0]         enq_v2,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]  cdb_id,
  input  logic [N_CDB*XLEN-1:0]   cdb_val,
  input  logic                    mem_busy,
  input  logic                    io_full,
  input  logic                    commit_store,
  output logic                    front_valid,
  output logic                    front_is_store,
  output logic                    front_ready,
  output logic [OP_W-1:0]         front_op,
  output logic [ROB_W-1:0]        front_rob_id,
  output logic [XLEN-1:0]         front_addr,
  output logic [XLEN-1:0]         front_data,
  output logic                    mem_req_valid,
  output logic [OP_W-1:0]         mem_req_op,
  output logic [XLEN-1:0]         mem_req_addr,
  output logic [ROB_W-1:0]        mem_req_id,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;

  logic             st_q   [DEPTH];
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [ROB_W-1:0] id_q   [DEPTH];
  logic [ROB_W:0]   q1_q   [DEPTH];
  logic [ROB_W:0]   q2_q   [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];

  logic [ROB_W:0]   snp_q1   [DEPTH];
  logic [ROB_W:0]   snp_q2   [DEPTH];
  logic [XLEN-1:0]  snp_addr [DEPTH];
  logic [XLEN-1:0]  snp_data [DEPTH];

  logic             mem_req_valid_q;
  logic [OP_W-1:0]  mem_req_op_q;
  logic [XLEN-1:0]  mem_req_addr_q;
  logic [ROB_W-1:0] mem_req_id_q;

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, io_ok, load_issue, store_pop, do_pop, do_enq;
  logic [XLEN-1:0]  enq_base;
  logic [ROB_W:0]   byp_q1, byp_q2;
  logic [XLEN-1:0]  byp_addr, byp_data;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  assign enq_ready      = !full;
  assign front_valid    = (head_q != tail_q);
  assign front_is_store = st_q[head_idx];
  assign front_op       = op_q[head_idx];
  assign front_rob_id   = id_q[head_idx];
  assign front_addr     = addr_q[head_idx];
  assign front_data     = data_q[head_idx];
  assign front_ready    = (&q1_q[head_idx]) && (!st_q[head_idx] || (&q2_q[head_idx]));

`ifdef LSB_IO_GUARD_EN
  assign io_ok = !(io_full && (front_addr == XLEN'(IO_ADDR)));
`else
  logic unused_io_full;
  assign unused_io_full = io_full;
  assign io_ok          = 1'b1;
`endif

  assign load_issue = front_valid && !front_is_store && (&q1_q[head_idx]) && !mem_busy && io_ok;
  assign store_pop  = commit_store && front_valid && front_is_store && front_ready;
  assign do_pop     = load_issue || store_pop;
  assign do_enq     = enq_valid && !full && !stall && !flush;

  // Unresolved base keeps only the offset; the CDB value is added on capture.
  assign enq_base = (&enq_q1) ? (enq_v1 + enq_imm) : enq_imm;

  lsb_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .ROB_W(ROB_W), .ADD_EN(1'b1)) u_byp_base (
    .q_i(enq_q1), .v_i(enq_base), .cdb_valid_i(cdb_valid), .cdb_id_i(cdb_id),
    .cdb_val_i(cdb_val), .q_o(byp_q1), .v_o(byp_addr)
  );

  lsb_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .ROB_W(ROB_W), .ADD_EN(1'b0)) u_byp_data (
    .q_i(enq_q2), .v_i(enq_v2), .cdb_valid_i(cdb_valid), .cdb_id_i(cdb_id),
    .cdb_val_i(cdb_val), .q_o(byp_q2), .v_o(byp_data)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    lsb_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .ROB_W(ROB_W), .ADD_EN(1'b1)) u_base (
      .q_i(q1_q[gi]), .v_i(addr_q[gi]), .cdb_valid_i(cdb_valid), .cdb_id_i(cdb_id),
      .cdb_val_i(cdb_val), .q_o(snp_q1[gi]), .v_o(snp_addr[gi])
    );
    lsb_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .ROB_W(ROB_W), .ADD_EN(1'b0)) u_data (
      .q_i(q2_q[gi]), .v_i(data_q[gi]), .cdb_valid_i(cdb_valid), .cdb_id_i(cdb_id),
      .cdb_val_i(cdb_val), .q_o(snp_q2[gi]), .v_o(snp_data[gi])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      tail_d  = head_q;
      count_d = '0;
    end else begin
      if (do_pop) head_d = head_q + PTR_W'(1);
      if (do_enq) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + PTR_W'(do_enq) - PTR_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        head_q          <= '0;
        tail_q          <= '0;
        count_q         <= '0;
        mem_req_valid_q <= 1'b0;
        mem_req_op_q    <= '0;
        mem_req_addr_q  <= '0;
        mem_req_id_q    <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          st_q[i]   <= 1'b0;
          op_q[i]   <= '0;
          id_q[i]   <= '0;
          q1_q[i]   <= '1;
          q2_q[i]   <= '1;
          addr_q[i] <= '0;
          data_q[i] <= '0;
        end
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        for (int i = 0; i < DEPTH; i++) begin
          q1_q[i]   <= snp_q1[i];
          q2_q[i]   <= snp_q2[i];
          addr_q[i] <= snp_addr[i];
          data_q[i] <= snp_data[i];
        end
        if (do_enq) begin
          st_q[tail_idx]   <= enq_is_store;
          op_q[tail_idx]   <= enq_op;
          id_q[tail_idx]   <= enq_rob_id;
          q1_q[tail_idx]   <= byp_q1;
          addr_q[tail_idx] <= byp_addr;
          q2_q[tail_idx]   <= enq_is_store ? byp_q2 : '1;
          data_q[tail_idx] <= byp_data;
        end
        mem_req_valid_q <= load_issue && !flush;
        if (load_issue && !flush) begin
          mem_req_op_q   <= front_op;
          mem_req_addr_q <= front_addr;
          mem_req_id_q   <= front_rob_id;
        end
      end
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_op    = mem_req_op_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_id    = mem_req_id_q;
  assign count         = count_q;

endmodule

`default_nettype wire
